// File: rtl/timer_multi_pkg.sv
// Shared register map and bit positions for the multi-channel timer.
package timer_multi_pkg;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIOD_L = 3'd2;
    localparam logic [2:0] OFF_PERIOD_H = 3'd3;
    localparam logic [2:0] OFF_SNAP_L   = 3'd4;
    localparam logic [2:0] OFF_SNAP_H   = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;
    localparam logic [2:0] OFF_RESERVED = 3'd7;

    localparam int ST_TO     = 0;
    localparam int ST_RUN    = 1;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;
    localparam int CTL_TOE   = 4;

    typedef struct packed {
        logic toe;
        logic cont;
        logic ito;
    } ctrl_t;

endpackage

// File: rtl/timer_multi_chan.sv
// One timer channel: prescaler, down-counter, control/status, snapshot and toggle output.
module timer_multi_chan
    import timer_multi_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          PRE_W      = 8,
    parameter int unsigned DEF_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_off,
    input  logic [15:0]      wr_data,
    output logic             run,
    output logic             to,
    output logic             toe,
    output logic             cont,
    output logic             ito,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale,
    output logic             irq,
    output logic             tog
);

    localparam int HI_W = CNT_W - 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             run_q, run_d;
    logic             to_q, to_d;
    logic             tog_q, tog_d;
    logic             reload_q, reload_d;
    logic             tick;
    logic             timeout;

    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        ctrl_d     = ctrl_q;
        run_d      = run_q;
        to_d       = to_q;
        tog_d      = tog_q;
        reload_d   = 1'b0;
        tick       = 1'b0;
        timeout    = 1'b0;

        // A period write takes effect one cycle later, so both halves see the new value.
        if (reload_q) begin
            cnt_d     = period_q;
            run_d     = 1'b0;
            pre_cnt_d = prescale_q;
        end else if (run_q) begin
            if (pre_cnt_q == '0) begin
                tick      = 1'b1;
                pre_cnt_d = prescale_q;
            end else begin
                pre_cnt_d = pre_cnt_q - 1'b1;
            end
        end

        if (tick) begin
            if (cnt_q == '0) begin
                timeout = 1'b1;
                cnt_d   = period_q;
                if (!ctrl_q.cont) run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (wr_en) begin
            case (wr_off)
                OFF_STATUS:   to_d = 1'b0;
                OFF_CONTROL: begin
                    ctrl_d.toe  = wr_data[CTL_TOE];
                    ctrl_d.cont = wr_data[CTL_CONT];
                    ctrl_d.ito  = wr_data[CTL_ITO];
                    if (wr_data[CTL_START]) begin
                        run_d     = 1'b1;
                        pre_cnt_d = prescale_q;
                    end
                    if (wr_data[CTL_STOP]) run_d = 1'b0;
                end
                OFF_PERIOD_L: begin
                    period_d[15:0] = wr_data;
                    reload_d       = 1'b1;
                end
                OFF_PERIOD_H: begin
                    period_d[CNT_W-1:16] = wr_data[HI_W-1:0];
                    reload_d             = 1'b1;
                end
                OFF_SNAP_L, OFF_SNAP_H: snap_d = cnt_q;
                OFF_PRESCALE: begin
                    prescale_d = wr_data[PRE_W-1:0];
                    pre_cnt_d  = wr_data[PRE_W-1:0];
                end
                default: ;
            endcase
        end

        // Applied last so a timeout beats a coincident status-write clear.
        if (timeout) begin
            to_d = 1'b1;
            if (ctrl_q.toe) tog_d = ~tog_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= CNT_W'(DEF_PERIOD);
            period_q   <= CNT_W'(DEF_PERIOD);
            snap_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            ctrl_q     <= '0;
            run_q      <= 1'b0;
            to_q       <= 1'b0;
            tog_q      <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            ctrl_q     <= ctrl_d;
            run_q      <= run_d;
            to_q       <= to_d;
            tog_q      <= tog_d;
            reload_q   <= reload_d;
        end
    end

    assign run      = run_q;
    assign to       = to_q;
    assign toe      = ctrl_q.toe;
    assign cont     = ctrl_q.cont;
    assign ito      = ctrl_q.ito;
    assign period   = period_q;
    assign snap     = snap_q;
    assign prescale = prescale_q;
    assign irq      = to_q & ctrl_q.ito;
    assign tog      = tog_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer top: address decode, registered read mux and interrupt OR.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int          PRE_W      = 8,
    parameter int unsigned DEF_PERIOD = 49999
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_CH)+2:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [15:0]                 writedata,
    output logic [15:0]                 readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_vec,
    output logic [NUM_CH-1:0]           tog_out
);

    localparam int AW   = $clog2(NUM_CH) + 3;
    localparam int HI_W = CNT_W - 16;

    logic [AW-1:0]                ch_sel;
    logic                         wr_strobe;
    logic [NUM_CH-1:0][15:0]      chan_rd;
    logic [15:0]                  rd_q, rd_d;

    assign ch_sel    = address >> 3;
    assign wr_strobe = chipselect & ~write_n;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic             run_w, to_w, toe_w, cont_w, ito_w;
        logic [CNT_W-1:0] period_w, snap_w;
        logic [PRE_W-1:0] prescale_w;
        logic [15:0]      rd_word;

        timer_multi_chan #(
            .CNT_W      (CNT_W),
            .PRE_W      (PRE_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst      (reset),
            .wr_en    (wr_strobe && (ch_sel == AW'(gi))),
            .wr_off   (address[2:0]),
            .wr_data  (writedata),
            .run      (run_w),
            .to       (to_w),
            .toe      (toe_w),
            .cont     (cont_w),
            .ito      (ito_w),
            .period   (period_w),
            .snap     (snap_w),
            .prescale (prescale_w),
            .irq      (irq_vec[gi]),
            .tog      (tog_out[gi])
        );

        always_comb begin
            rd_word = '0;
            case (address[2:0])
                OFF_STATUS: begin
                    rd_word[ST_RUN] = run_w;
                    rd_word[ST_TO]  = to_w;
                end
                OFF_CONTROL: begin
                    rd_word[CTL_TOE]  = toe_w;
                    rd_word[CTL_CONT] = cont_w;
                    rd_word[CTL_ITO]  = ito_w;
                end
                OFF_PERIOD_L: rd_word            = period_w[15:0];
                OFF_PERIOD_H: rd_word[HI_W-1:0]  = period_w[CNT_W-1:16];
                OFF_SNAP_L:   rd_word            = snap_w[15:0];
                OFF_SNAP_H:   rd_word[HI_W-1:0]  = snap_w[CNT_W-1:16];
                OFF_PRESCALE: rd_word[PRE_W-1:0] = prescale_w;
                default: ;
            endcase
        end

        assign chan_rd[gi] = rd_word;
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == AW'(i)) rd_d = chan_rd[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    assign readdata = rd_q;
    assign irq      = |irq_vec;

endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter/period width in bits (17..32).
REQ-003 Parameter PRE_W, default 8, prescaler width in bits (1..16).
REQ-004 Parameter DEF_PERIOD, default 49999, reset value of every period register and counter.
REQ-005 Port clk  in  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-006 Port reset  in  1  asynchronous active-high reset.
REQ-007 Port address  in  clog2(NUM_CH)+3  {channel, register offset[2:0]}.
REQ-008 Port chipselect  in  1  slave select.
REQ-009 Port write_n  in  1  active-low write strobe, valid with chipselect.
REQ-010 Port writedata  in  16  write data.
REQ-011 Port readdata  out  16  registered read data.
REQ-012 Port irq  out  1  OR of all irq_vec bits.
REQ-013 Port irq_vec  out  NUM_CH  per-channel interrupt.
REQ-014 Port tog_out  out  NUM_CH  per-channel toggle output.

Function
REQ-015 Per-channel offsets SHALL be: 0 status {RUN[1],TO[0]}, 1 control {TOE[4],STOP[3],START[2],CONT[1],ITO[0]}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h, 6 prescale, 7 reserved (reads 0, writes ignored).
REQ-016 Read latency SHALL be exactly 1 cycle; unused upper bits and channel indices >= NUM_CH SHALL read 0.
REQ-017 period_h SHALL hold bits CNT_W-1:16; writes to bits above CNT_W-1 are discarded and read as 0.
REQ-018 Prescaler: tick SHALL assert every (prescale+1) clocks while RUN=1; prescale=0 ticks every cycle; prescaler count SHALL reload on prescale write, on start, and on force reload.
REQ-019 On tick with counter!=0, counter SHALL decrement by 1; on tick with counter==0, timeout event SHALL occur and counter SHALL load period.
REQ-020 One timeout therefore occurs every (period+1)*(prescale+1) clocks.
REQ-021 Timeout with CONT=0 SHALL clear RUN in the same cycle as the reload.
REQ-022 Write to period_l or period_h SHALL, on the following cycle, load counter from period, clear RUN and reset the prescaler (force reload).
REQ-023 Control write with START=1 SHALL set RUN; STOP=1 SHALL clear RUN; both set: STOP wins; STOP and START bits are not stored (read 0).
REQ-024 TO SHALL set on timeout event and clear on any status write; same-cycle timeout and status write: TO set wins.
REQ-025 irq_vec[n] SHALL equal TO[n] AND ITO[n]; irq SHALL be combinational OR of irq_vec.
REQ-026 tog_out[n] SHALL invert on each timeout event when TOE=1, and hold otherwise.
REQ-027 Write to snap_l or snap_h SHALL capture the current counter into the snapshot register; reading snap returns the captured value.
REQ-028 Stopped channel SHALL hold counter value; restart resumes from held value.

Reset
REQ-029 On reset: counter and period = DEF_PERIOD, prescale=0, control=0, RUN=0, TO=0, snapshot=0, readdata=0, irq=0, irq_vec=0, tog_out=0.
REQ-030 Reset mid-count SHALL abort immediately with no timeout event and no toggle.

Structure
REQ-031 Package timer_multi_pkg SHALL hold register offsets and control/status bit positions.
REQ-032 Per-channel logic SHALL be sub-module timer_multi_chan, instantiated NUM_CH times; the top holds decode, read mux and irq OR.

Verification
REQ-033 ch0 period=9, prescale=0, CONT=1, ITO=1, START -> TO/irq every 10 clocks, RUN stays 1.
REQ-034 ch2 period=3, prescale=4, CONT=0, START -> single timeout after 20 clocks, RUN=0, counter=3.
REQ-035 ch1 running, write period_l=100 -> next cycle RUN=0, counter=100 (snapshot readback confirms).
REQ-036 Control write START=1,STOP=1 -> RUN=0; status write coincident with timeout -> TO=1.
REQ-037 ch3 TOE=1, period=1, CONT=1, 4 timeouts -> tog_out[3] toggles 4 times, ends 0.
REQ-038 Reset asserted mid-count -> all outputs 0, counter=DEF_PERIOD, read of address 7 returns 0.
